// File: rtl/sad_engine_param.sv
// Block-match engine: streams LANES pixel pairs per cycle and writes one SAD/SSD per block, tracking the minimum.
// Latency W+2 cycles per block; no backpressure, the SRAMs are assumed to serve every read and write issued.
module sad_engine_param #(
  parameter int PIX_W      = 8,
  parameter int LANES      = 1,
  parameter int BLOCK_SIZE = 256,
  parameter int NUM_BLOCKS = 128,
  parameter int A_ADDR_W   = 15,
  parameter int C_ADDR_W   = 7,
  parameter int SUM_W      = 32
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Go,
  input  logic                   Mode,
  input  logic [LANES*PIX_W-1:0] A_Data,
  input  logic [LANES*PIX_W-1:0] B_Data,
  output logic [A_ADDR_W-1:0]    A_Addr,
  output logic [A_ADDR_W-1:0]    B_Addr,
  output logic                   AB_En,
  output logic                   AB_Rd,
  output logic [C_ADDR_W-1:0]    C_Addr,
  output logic                   C_En,
  output logic                   C_Wr,
  output logic [SUM_W-1:0]       Sad_Out,
  output logic [SUM_W-1:0]       Min_Sad,
  output logic [C_ADDR_W-1:0]    Min_Idx,
  output logic                   Busy,
  output logic                   Done
);

  localparam int W      = BLOCK_SIZE / LANES;
  localparam int WC_W   = (W > 1) ? $clog2(W) : 1;
  localparam int TERM_W = 2 * PIX_W;
  localparam int TREE_W = TERM_W + $clog2(LANES);
  localparam int EXT_W  = ((TREE_W > SUM_W) ? TREE_W : SUM_W) + 1;

  localparam logic [SUM_W-1:0]    SUM_MAX  = '1;
  localparam logic [WC_W-1:0]     W_LAST   = WC_W'(W - 1);
  localparam logic [C_ADDR_W-1:0] BLK_LAST = C_ADDR_W'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t              state;
  logic                mode_r;
  logic                go_armed;
  logic                rd_vld;
  logic [WC_W-1:0]     wcnt;
  logic [C_ADDR_W-1:0] blk;
  logic [SUM_W-1:0]    acc;

  logic [PIX_W-1:0]    pa, pb, diff;
  logic [TERM_W-1:0]   term;
  logic [TREE_W-1:0]   tree_sum;
  logic [EXT_W-1:0]    sum_ext;
  logic [SUM_W-1:0]    acc_next;

  assign B_Addr = A_Addr;

  // Per-lane |a-b| or (a-b)^2, summed across lanes.
  always_comb begin
    tree_sum = '0;
    pa       = '0;
    pb       = '0;
    diff     = '0;
    term     = '0;
    for (int i = 0; i < LANES; i++) begin
      pa       = A_Data[i*PIX_W +: PIX_W];
      pb       = B_Data[i*PIX_W +: PIX_W];
      diff     = (pa >= pb) ? (pa - pb) : (pb - pa);
      term     = mode_r ? (TERM_W'(diff) * TERM_W'(diff)) : TERM_W'(diff);
      tree_sum = tree_sum + TREE_W'(term);
    end
  end

  // Widened add so a single word that alone exceeds SUM_W still clamps.
  always_comb begin
    sum_ext = EXT_W'(acc);
    if (rd_vld) sum_ext = sum_ext + EXT_W'(tree_sum);
    acc_next = (sum_ext > EXT_W'(SUM_MAX)) ? SUM_MAX : sum_ext[SUM_W-1:0];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_IDLE;
      mode_r   <= 1'b0;
      go_armed <= 1'b1;
      rd_vld   <= 1'b0;
      wcnt     <= '0;
      blk      <= '0;
      acc      <= '0;
      A_Addr   <= '0;
      AB_En    <= 1'b0;
      AB_Rd    <= 1'b0;
      C_Addr   <= '0;
      C_En     <= 1'b0;
      C_Wr     <= 1'b0;
      Sad_Out  <= '0;
      Min_Sad  <= SUM_MAX;
      Min_Idx  <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      if (!Go) go_armed <= 1'b1;
      rd_vld <= AB_Rd;
      case (state)
        S_IDLE: begin
          // A held Go starts one run only; it must drop before it can start another.
          if (Go && go_armed) begin
            state    <= S_LOAD;
            go_armed <= 1'b0;
            mode_r   <= Mode;
            blk      <= '0;
            acc      <= '0;
            Min_Sad  <= SUM_MAX;
            Min_Idx  <= '0;
            Busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          state  <= S_RUN;
          AB_En  <= 1'b1;
          AB_Rd  <= 1'b1;
          A_Addr <= '0;
          wcnt   <= '0;
        end
        S_RUN: begin
          acc <= acc_next;
          if (wcnt == W_LAST) begin
            state <= S_DRAIN;
            AB_En <= 1'b0;
            AB_Rd <= 1'b0;
          end else begin
            wcnt   <= wcnt + 1'b1;
            A_Addr <= A_Addr + 1'b1;
          end
        end
        S_DRAIN: begin
          state   <= S_WRITE;
          C_En    <= 1'b1;
          C_Wr    <= 1'b1;
          C_Addr  <= blk;
          Sad_Out <= acc_next;
          acc     <= '0;
        end
        S_WRITE: begin
          C_En <= 1'b0;
          C_Wr <= 1'b0;
          if (Sad_Out < Min_Sad) begin
            Min_Sad <= Sad_Out;
            Min_Idx <= blk;
          end
          if (blk == BLK_LAST) begin
            state <= S_DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end else begin
            // Blocks are contiguous in the operand SRAMs, so the address just continues.
            state  <= S_RUN;
            blk    <= blk + 1'b1;
            AB_En  <= 1'b1;
            AB_Rd  <= 1'b1;
            A_Addr <= A_Addr + 1'b1;
            wcnt   <= '0;
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_engine_param.sv
// Bench for sad_engine_param: 4-lane, 16-bit-result configuration against a per-block arithmetic model and run timeline.
module tb_sad_engine_param;

  localparam int PW = 8;
  localparam int LN = 4;
  localparam int BS = 32;
  localparam int NB = 12;
  localparam int AW = 7;
  localparam int CW = 4;
  localparam int SW = 16;
  localparam int W  = BS / LN;
  localparam int NW = NB * W;
  localparam int DONE_N = NB * (W + 2) + 2;
  localparam longint SMAX = 65535;

  logic Clk = 1'b0;
  logic Rst, Go, Mode;
  logic [LN*PW-1:0] A_Data, B_Data;
  logic [AW-1:0] A_Addr, B_Addr;
  logic AB_En, AB_Rd;
  logic [CW-1:0] C_Addr;
  logic C_En, C_Wr;
  logic [SW-1:0] Sad_Out, Min_Sad;
  logic [CW-1:0] Min_Idx;
  logic Busy, Done;

  sad_engine_param #(
    .PIX_W(PW), .LANES(LN), .BLOCK_SIZE(BS), .NUM_BLOCKS(NB),
    .A_ADDR_W(AW), .C_ADDR_W(CW), .SUM_W(SW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Go(Go), .Mode(Mode),
    .A_Data(A_Data), .B_Data(B_Data),
    .A_Addr(A_Addr), .B_Addr(B_Addr), .AB_En(AB_En), .AB_Rd(AB_Rd),
    .C_Addr(C_Addr), .C_En(C_En), .C_Wr(C_Wr),
    .Sad_Out(Sad_Out), .Min_Sad(Min_Sad), .Min_Idx(Min_Idx),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  logic [LN*PW-1:0] mem_a [NW];
  logic [LN*PW-1:0] mem_b [NW];
  longint exp_res [NB];
  longint exp_min, idle_min;
  int     exp_idx, idle_idx;
  int  n_cmp = 0;
  int  n_fail = 0;
  bit  go_pending = 0;
  bit  active = 0;
  int  off = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: each block result is the clamped sum of all lane terms; minimum is first strict-smallest.
  task automatic compute_model(input bit mode);
    longint s;
    int a, b, d;
    for (int blk = 0; blk < NB; blk++) begin
      s = 0;
      for (int w = 0; w < W; w++)
        for (int l = 0; l < LN; l++) begin
          a = int'(mem_a[blk*W+w][l*PW +: PW]);
          b = int'(mem_b[blk*W+w][l*PW +: PW]);
          d = (a > b) ? a - b : b - a;
          s += mode ? longint'(d * d) : longint'(d);
        end
      exp_res[blk] = (s > SMAX) ? SMAX : s;
    end
    exp_min = SMAX;
    exp_idx = 0;
    for (int blk = 0; blk < NB; blk++)
      if (exp_res[blk] < exp_min) begin
        exp_min = exp_res[blk];
        exp_idx = blk;
      end
  endtask

  task automatic fill(input int kind);
    logic [7:0] a, b, t;
    for (int i = 0; i < NW; i++)
      for (int l = 0; l < LN; l++) begin
        b = 8'($urandom);
        case (kind)
          0: begin b = 8'($urandom_range(0, 254)); a = b + 8'd1; end
          1: begin a = 8'h03; b = 8'h00; end
          2: begin a = 8'hFF; b = 8'h00; end
          3: a = b ^ 8'h01;
          4: a = 8'($urandom);
          default: begin
            a = (b < 8'd250) ? b + 8'($urandom_range(0, 5)) : b;
            if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
          end
        endcase
        mem_a[i][l*PW +: PW] = a;
        mem_b[i][l*PW +: PW] = b;
      end
  endtask

  // One-cycle-latency operand SRAM pair.
  initial begin
    bit rd;
    logic [AW-1:0] ad;
    forever begin
      @(posedge Clk);
      rd = AB_En && AB_Rd;
      ad = A_Addr;
      #1;
      if (rd && ad < NW) begin
        A_Data = mem_a[ad];
        B_Data = mem_b[ad];
      end
    end
  end

  // Run position: off=1 is the cycle after Go is sampled.
  always @(posedge Clk) begin
    if (!Rst) begin
      active     = 0;
      go_pending = 0;
    end else if (go_pending) begin
      go_pending = 0;
      active     = 1;
      off        = 1;
    end else if (active) begin
      off++;
      if (off > DONE_N) active = 0;
    end
  end

  always @(negedge Clk) begin : cmp
    int n, p, b;
    bit inblk, run, wr;
    if (!Rst) begin
      check("rst_ctl", {AB_En, AB_Rd, C_En, C_Wr, Busy, Done}, 0);
      check("rst_a_addr", A_Addr, 0);
      check("rst_c_addr", C_Addr, 0);
      check("rst_sad_out", Sad_Out, 0);
      check("rst_min_sad", Min_Sad, SMAX);
      check("rst_min_idx", Min_Idx, 0);
      idle_min = SMAX;
      idle_idx = 0;
    end else if (active) begin
      n     = off;
      inblk = (n >= 2) && (n <= DONE_N - 1);
      p     = (n - 2) % (W + 2);
      b     = (n - 2) / (W + 2);
      run   = inblk && (p < W);
      wr    = inblk && (p == W + 1);
      check("busy", Busy, n <= DONE_N - 1);
      check("done", Done, n == DONE_N);
      check("ab_en", AB_En, run);
      check("ab_rd", AB_Rd, run);
      check("c_en", C_En, wr);
      check("c_wr", C_Wr, wr);
      if (run) begin
        check("a_addr", A_Addr, b * W + p);
        check("b_addr", B_Addr, b * W + p);
      end
      if (wr) begin
        check("c_addr", C_Addr, b);
        check("sad_out", Sad_Out, exp_res[b]);
      end
      if (n == DONE_N) begin
        check("min_sad", Min_Sad, exp_min);
        check("min_idx", Min_Idx, exp_idx);
        idle_min = exp_min;
        idle_idx = exp_idx;
      end
    end else begin
      check("idle_ctl", {AB_En, AB_Rd, C_En, C_Wr, Busy, Done}, 0);
      check("idle_min_sad", Min_Sad, idle_min);
      check("idle_min_idx", Min_Idx, idle_idx);
    end
  end

  task automatic tick;
    @(posedge Clk);
    #2;
  endtask

  task automatic run_block(input bit mode, input bit hold, input bit pulse);
    int cyc;
    compute_model(mode);
    Mode = mode;
    Go = 1'b1;
    go_pending = 1;
    tick();
    Mode = 1'($urandom);
    if (!hold) Go = 1'b0;
    cyc = 1;
    while (!Done && cyc < 400) begin
      if (pulse && (cyc == 30 || cyc == 70)) Go = 1'b1;
      else if (!hold) Go = 1'b0;
      tick();
      cyc++;
    end
    check("go_to_done_cycles", cyc, 122);
  endtask

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    Rst = 1'b1; Go = 1'b0; Mode = 1'b0;
    A_Data = '0; B_Data = '0;
    idle_min = SMAX; idle_idx = 0;
    #1 Rst = 1'b0;
    repeat (3) tick();
    Rst = 1'b1;
    repeat (2) tick();

    // SAD with A = B + 1 on every pixel: every block is 32, tie keeps block 0.
    fill(0);
    run_block(1'b0, 1'b0, 1'b0);
    check("t1_model_blk0", exp_res[0], 32);
    check("t1_min_sad", Min_Sad, 32);
    check("t1_min_idx", Min_Idx, 0);
    repeat (3) tick();

    // SSD with difference 3: 32 * 9 = 288 per block.
    fill(1);
    run_block(1'b1, 1'b0, 1'b0);
    check("t3_model_blk3", exp_res[3], 288);
    check("t3_min_sad", Min_Sad, 288);
    repeat (3) tick();

    // SSD 0xFF vs 0x00 clamps at 0xFFFF; Go held high across the whole run.
    fill(2);
    run_block(1'b1, 1'b1, 1'b0);
    check("t4_model_blk5", exp_res[5], 16'hFFFF);
    check("t4_min_sad", Min_Sad, 16'hFFFF);
    check("t4_min_idx", Min_Idx, 0);
    repeat (5) tick();
    Go = 1'b0;
    repeat (3) tick();

    // Only block 7 matches exactly; stray Go pulses mid-run.
    fill(3);
    for (int w = 0; w < W; w++) mem_a[7*W+w] = mem_b[7*W+w];
    run_block(1'b0, 1'b0, 1'b1);
    check("t5_model_blk7", exp_res[7], 0);
    check("t5_min_sad", Min_Sad, 0);
    check("t5_min_idx", Min_Idx, 7);
    repeat (3) tick();

    // Reset during block 5 RUN, then a full rerun.
    fill(4);
    compute_model(1'b0);
    Mode = 1'b0;
    Go = 1'b1;
    go_pending = 1;
    tick();
    Go = 1'b0;
    repeat (54) tick();
    Rst = 1'b0;
    repeat (3) tick();
    Rst = 1'b1;
    repeat (2) tick();
    run_block(1'b0, 1'b0, 1'b0);
    repeat (2) tick();

    for (int r = 0; r < 6; r++) begin
      fill((r % 2 == 1) ? 4 : 5);
      if (r == 2) begin
        int bb;
        bb = $urandom_range(0, NB - 1);
        for (int w = 0; w < W; w++) mem_a[bb*W+w] = mem_b[bb*W+w];
      end
      run_block(1'($urandom), 1'b0, 1'b0);
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
